emif_shim_cmd_split: RTL and testbench

Command splitter directly upstream of the EMIF shim skid buffer. Accepts one read/write command of up to 2^P_LEN_W beats and emits a sequence of EMIF-legal sub-commands: each at most P_MAX_BURST beats and never crossing a P_BOUNDARY-byte address boundary. The registered valid/ready output stream feeds the skid stage in front of the EMIF.

---
 rtl/emif_shim_cmd_split.sv | 174 +++++++++++++++++
 tb/tb_emif_shim_cmd_split.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/emif_shim_cmd_split.sv
// emif_shim_cmd_split
//
// Splits one read/write command of up to 2^P_LEN_W beats into a run of
// sub-commands. Each sub-command is at most P_MAX_BURST beats and never
// crosses a P_BOUNDARY-byte address boundary. Output goes to the skid stage
// in front of the EMIF.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   parent command handshake (accepted only when idle)
//   in_addr             start byte address; sub-beat bits are ignored
//   in_len              parent length, beats-1
//   in_write            1 = write, 0 = read
//   out_valid/out_ready sub-command handshake
//   out_addr            beat-aligned sub-command address
//   out_len             sub-command length, beats-1
//   out_write           write flag of the parent
//   out_last            final sub-command of the parent
//   busy                a parent command is being split
//
// Every output comes straight from a flop, so there is no combinational path
// from in_* or out_ready to any output.

module emif_shim_cmd_split #(
   parameter int unsigned P_ADDR_W         = 32,
   parameter int unsigned P_LEN_W          = 8,
   parameter int unsigned P_MAX_BURST      = 16,
   parameter int unsigned P_BYTES_PER_BEAT = 64,
   parameter int unsigned P_BOUNDARY       = 4096
) (
   input  logic                           clk,
   input  logic                           rst_n,

   input  logic                           in_valid,
   input  logic [P_ADDR_W-1:0]            in_addr,
   input  logic [P_LEN_W-1:0]             in_len,
   input  logic                           in_write,
   output logic                           in_ready,

   output logic                           out_valid,
   output logic [P_ADDR_W-1:0]            out_addr,
   output logic [$clog2(P_MAX_BURST)-1:0] out_len,
   output logic                           out_write,
   output logic                           out_last,
   input  logic                           out_ready,

   output logic                           busy
);

   localparam int unsigned LenOutW = $clog2(P_MAX_BURST);
   localparam int unsigned BeatW   = $clog2(P_BYTES_PER_BEAT);
   // Remaining beats reach in_len+1, which needs one bit more than in_len.
   localparam int unsigned RemW    = P_LEN_W + 1;
   // Working width for the beat-count minimum; wide enough for every operand.
   localparam int unsigned CntW    = 32;

   localparam logic [P_ADDR_W-1:0] AlignMask = ~P_ADDR_W'(P_BYTES_PER_BEAT - 1);
   localparam logic [P_ADDR_W-1:0] BndMask   = P_ADDR_W'(P_BOUNDARY - 1);

   typedef enum logic [0:0] {
      StIdle,
      StSplit
   } state_e;

   state_e               state_q, state_d;
   // Beats still owed to the parent, including the sub-command on the output.
   logic [RemW-1:0]      rem_q, rem_d;
   logic [P_ADDR_W-1:0]  out_addr_q, out_addr_d;
   logic [LenOutW-1:0]   out_len_q, out_len_d;
   logic                 out_write_q, out_write_d;
   logic                 out_last_q, out_last_d;

   // Source of the sub-command being loaded next.
   logic                 load;
   logic [P_ADDR_W-1:0]  src_addr;
   logic [RemW-1:0]      src_rem;

   logic [RemW-1:0]      cur_beats;
   logic [P_ADDR_W-1:0]  next_addr;
   logic [CntW-1:0]      bnd_room;
   logic [CntW-1:0]      beats;

   // Beats and byte stride of the sub-command currently presented.
   always_comb begin
      cur_beats = RemW'(out_len_q) + RemW'(1);
      // Natural P_ADDR_W-bit overflow gives the required wrap to 0.
      next_addr = out_addr_q + ((P_ADDR_W'(out_len_q) + P_ADDR_W'(1)) << BeatW);
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      out_addr_d  = out_addr_q;
      out_len_d   = out_len_q;
      out_write_d = out_write_q;
      out_last_d  = out_last_q;

      load     = 1'b0;
      src_addr = out_addr_q;
      src_rem  = rem_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               load        = 1'b1;
               src_addr    = in_addr & AlignMask;
               src_rem     = RemW'(in_len) + RemW'(1);
               out_write_d = in_write;
               state_d     = StSplit;
            end
         end
         StSplit: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d = StIdle;
                  rem_d   = '0;
               end else begin
                  load     = 1'b1;
                  src_addr = next_addr;
                  src_rem  = rem_q - cur_beats;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // beats = min(remaining, max burst, beats left before the boundary).
      // bnd_room is always >= 1 because the address is beat-aligned.
      bnd_room = (CntW'(P_BOUNDARY) - CntW'(src_addr & BndMask)) >> BeatW;
      beats    = CntW'(src_rem);
      if (beats > CntW'(P_MAX_BURST)) begin
         beats = CntW'(P_MAX_BURST);
      end
      if (beats > bnd_room) begin
         beats = bnd_room;
      end

      if (load) begin
         rem_d      = src_rem;
         out_addr_d = src_addr;
         out_len_d  = LenOutW'(beats - CntW'(1));
         out_last_d = (beats == CntW'(src_rem));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rem_q       <= '0;
         out_addr_q  <= '0;
         out_len_q   <= '0;
         out_write_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         out_addr_q  <= out_addr_d;
         out_len_q   <= out_len_d;
         out_write_q <= out_write_d;
         out_last_q  <= out_last_d;
      end
   end

   // The output is valid for the whole time a parent is being split, so the
   // handshake flags decode directly from the state flop.
   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q == StSplit);
   assign out_valid = (state_q == StSplit);
   assign out_addr  = out_addr_q;
   assign out_len   = out_len_q;
   assign out_write = out_write_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_emif_shim_cmd_split.sv
// Testbench for emif_shim_cmd_split: directed scenarios plus randomized
// commands, each checked against a sub-command list computed arithmetically
// from the splitting rules.

module tb_emif_shim_cmd_split;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [7:0]  in_len;
   logic        in_write;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_addr;
   logic [3:0]  out_len;
   logic        out_write;
   logic        out_last;
   logic        out_ready;
   logic        busy;

   int n_checks;
   int n_pass;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  len;
      logic        last;
   } sub_t;

   sub_t exp_q[$];

   emif_shim_cmd_split dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_addr   (in_addr),
      .in_len    (in_len),
      .in_write  (in_write),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_addr  (out_addr),
      .out_len   (out_len),
      .out_write (out_write),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference: walk the parent, taking min(remaining, 16, room to 4 KiB) each step.
   task automatic build_exp(input logic [31:0] a_in, input int total);
      logic [31:0] a;
      int          rem;
      int          room;
      int          b;
      sub_t        s;
      exp_q.delete();
      a   = a_in & ~32'h3F;
      rem = total;
      while (rem > 0) begin
         room = (4096 - int'(a % 32'd4096)) / 64;
         b    = rem;
         if (b > 16) b = 16;
         if (b > room) b = room;
         s.addr = a;
         s.len  = 4'(b - 1);
         s.last = (b == rem);
         exp_q.push_back(s);
         a   = a + 32'(b * 64);
         rem = rem - b;
      end
   endtask

   // Called at a falling edge with the DUT idle. bp_at: sub-command index held
   // off for 5 cycles; rst_at: sub-command index during which reset is pulsed.
   task automatic run_cmd(input logic [31:0] a, input logic [7:0] l, input logic w,
                          input bit full_rdy, input int bp_at, input int rst_at);
      int idx;
      int cyc;
      int bp_cnt;
      bit rdy;
      build_exp(a, int'(l) + 1);
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
      in_valid  = 1'b1;
      in_addr   = a;
      in_len    = l;
      in_write  = w;
      out_ready = 1'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      idx      = 0;
      cyc      = 0;
      bp_cnt   = 0;
      while (idx < exp_q.size() && cyc < 4000) begin
         if (idx == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_out_addr", out_addr, 0);
            check("rst_out_len", out_len, 0);
            check("rst_out_write", out_write, 0);
            check("rst_out_last", out_last, 0);
            @(negedge clk);
            rst_n     = 1'b1;
            out_ready = 1'b0;
            return;
         end
         check("out_valid", out_valid, 1);
         check("out_addr", out_addr, exp_q[idx].addr);
         check("out_len", out_len, exp_q[idx].len);
         check("out_last", out_last, exp_q[idx].last);
         check("out_write", out_write, w);
         check("busy", busy, 1);
         check("split_in_ready", in_ready, 0);
         if (idx == bp_at && bp_cnt < 5) begin
            rdy = 1'b0;
            bp_cnt++;
         end else begin
            rdy = full_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
         out_ready = rdy;
         // Junk presented while busy must be ignored.
         in_valid  = 1'($urandom);
         in_addr   = $urandom;
         in_len    = 8'($urandom);
         in_write  = 1'($urandom);
         @(negedge clk);
         if (rdy) idx++;
         cyc++;
      end
      if (idx < exp_q.size()) check("timeout", 0, 1);
      in_valid  = 1'b0;
      out_ready = 1'($urandom);
      check("done_out_valid", out_valid, 0);
      check("done_in_ready", in_ready, 1);
      check("done_busy", busy, 0);
   endtask

   initial begin
      logic [31:0] r;
      int          sel;
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_addr   = '0;
      in_len    = '0;
      in_write  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("por_out_valid", out_valid, 0);
      check("por_in_ready", in_ready, 1);
      check("por_busy", busy, 0);
      check("por_out_addr", out_addr, 0);
      check("por_out_len", out_len, 0);
      check("por_out_last", out_last, 0);
      check("por_out_write", out_write, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_cmd(32'h0000_1000, 8'd7, 1'b1, 1'b1, -1, -1);
      run_cmd(32'h0000_0000, 8'd39, 1'b0, 1'b1, -1, -1);
      run_cmd(32'h0000_0FC0, 8'd3, 1'b0, 1'b1, -1, -1);
      run_cmd(32'h0000_0FC5, 8'd3, 1'b1, 1'b1, -1, -1);
      run_cmd(32'h0000_0000, 8'd39, 1'b1, 1'b1, 1, -1);
      run_cmd(32'h0000_0000, 8'd39, 1'b1, 1'b1, -1, 1);
      run_cmd(32'h0000_2000, 8'd0, 1'b1, 1'b1, -1, -1);
      run_cmd(32'hFFFF_FFC0, 8'd1, 1'b1, 1'b1, -1, -1);
      run_cmd(32'hFFFF_F400, 8'd255, 1'b0, 1'b0, -1, -1);

      for (int i = 0; i < 300; i++) begin
         r   = $urandom;
         sel = $urandom_range(0, 3);
         if (sel == 1) r[11:8] = 4'hF;
         if (sel == 2) r[31:12] = 20'hFFFFF;
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
         end
         run_cmd(r, 8'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
